// File: rtl/regs_wb_arbiter.sv
// Register-file write-port arbiter between the fixed-latency ALU writeback and a
// buffered LSU handshake source, with starvation hold and decode hazard detection.
module regs_wb_arbiter #(
    parameter int XLEN       = 64,
    parameter int AW         = 5,
    parameter int BUF_DEPTH  = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            alu_wen_i,
    input  logic [AW-1:0]   alu_waddr_i,
    input  logic [XLEN-1:0] alu_wdata_i,
    output logic            alu_hold_o,
    input  logic            lsu_valid_i,
    input  logic [AW-1:0]   lsu_waddr_i,
    input  logic [XLEN-1:0] lsu_wdata_i,
    output logic            lsu_ready_o,
    input  logic [AW-1:0]   dec_rs1_i,
    input  logic [AW-1:0]   dec_rs2_i,
    input  logic [AW-1:0]   dec_rd_i,
    output logic            hazard_o,
    output logic            reg_wen_o,
    output logic [AW-1:0]   reg_waddr_o,
    output logic [XLEN-1:0] reg_wdata_o
);

    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(BUF_DEPTH);
    localparam logic [SW-1:0] STARVE_C = SW'(STARVE_MAX);

    logic [AW-1:0]   addr_mem_r [BUF_DEPTH];
    logic [XLEN-1:0] data_mem_r [BUF_DEPTH];
    logic [PW-1:0]   rd_ptr_r, wr_ptr_r;
    logic [CW-1:0]   count_r, count_next_s;
    logic [SW-1:0]   starve_r, starve_next_s;
    logic            alu_hold_r, alu_hold_next_s;
    logic            empty_s, ready_s, push_s, pop_s, hit_s;
    logic [PW-1:0]   off_s;

    // x0 in a decode field never matches anything
    function automatic logic addr_hit(input logic [AW-1:0] a, input logic [AW-1:0] rs1,
                                      input logic [AW-1:0] rs2, input logic [AW-1:0] rd);
        return ((a == rs1) && (rs1 != {AW{1'b0}})) ||
               ((a == rs2) && (rs2 != {AW{1'b0}})) ||
               ((a == rd)  && (rd  != {AW{1'b0}}));
    endfunction

    assign empty_s     = (count_r == {CW{1'b0}});
    assign ready_s     = ~rst_i & (count_r != DEPTH_C);
    assign push_s      = lsu_valid_i & ready_s & (lsu_waddr_i != {AW{1'b0}});
    assign lsu_ready_o = ready_s;
    assign alu_hold_o  = alu_hold_r;

    // Write-port selection: starved buffer head, then ALU, then buffer head
    always_comb begin
        pop_s       = 1'b0;
        reg_wen_o   = 1'b0;
        reg_waddr_o = {AW{1'b0}};
        reg_wdata_o = {XLEN{1'b0}};
        if (rst_i) begin
            pop_s = 1'b0;
        end else if (alu_hold_r && !empty_s) begin
            pop_s       = 1'b1;
            reg_wen_o   = 1'b1;
            reg_waddr_o = addr_mem_r[rd_ptr_r];
            reg_wdata_o = data_mem_r[rd_ptr_r];
        end else if (alu_wen_i && !alu_hold_r && (alu_waddr_i != {AW{1'b0}})) begin
            reg_wen_o   = 1'b1;
            reg_waddr_o = alu_waddr_i;
            reg_wdata_o = alu_wdata_i;
        end else if (!empty_s) begin
            pop_s       = 1'b1;
            reg_wen_o   = 1'b1;
            reg_waddr_o = addr_mem_r[rd_ptr_r];
            reg_wdata_o = data_mem_r[rd_ptr_r];
        end else begin
            reg_wen_o = 1'b0;
        end
    end

    // Occupancy, starvation counter and hold next-state
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CW'(1);
            2'b01:   count_next_s = count_r - CW'(1);
            default: count_next_s = count_r;
        endcase
        if (empty_s || pop_s) begin
            starve_next_s = {SW{1'b0}};
        end else if (starve_r != STARVE_C) begin
            starve_next_s = starve_r + SW'(1);
        end else begin
            starve_next_s = starve_r;
        end
        if (alu_hold_r) begin
            alu_hold_next_s = ~pop_s;
        end else begin
            alu_hold_next_s = (starve_next_s == STARVE_C);
        end
    end

    // Hazard: occupied slots lie within count_r entries of the read pointer
    always_comb begin
        off_s = {PW{1'b0}};
        hit_s = lsu_valid_i & addr_hit(lsu_waddr_i, dec_rs1_i, dec_rs2_i, dec_rd_i);
        for (int i = 0; i < BUF_DEPTH; i++) begin
            off_s = PW'(i) - rd_ptr_r;
            hit_s = hit_s | ((CW'(off_s) < count_r) &&
                             addr_hit(addr_mem_r[i], dec_rs1_i, dec_rs2_i, dec_rd_i));
        end
        hazard_o = ~rst_i & hit_s;
    end

    // Control state; reset discards every buffered entry
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_r   <= {PW{1'b0}};
            wr_ptr_r   <= {PW{1'b0}};
            count_r    <= {CW{1'b0}};
            starve_r   <= {SW{1'b0}};
            alu_hold_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            count_r    <= count_next_s;
            starve_r   <= starve_next_s;
            alu_hold_r <= alu_hold_next_s;
        end
    end

    // Buffer storage; contents are qualified by count_r so it needs no reset
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            addr_mem_r[wr_ptr_r] <= lsu_waddr_i;
            data_mem_r[wr_ptr_r] <= lsu_wdata_i;
        end
    end

endmodule

// File: tb/tb_regs_wb_arbiter.sv
// Cycle-table bench for regs_wb_arbiter with per-source write-order scoreboards.
module tb_regs_wb_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        alu_wen_i;
    logic [4:0]  alu_waddr_i;
    logic [63:0] alu_wdata_i;
    logic        alu_hold_o;
    logic        lsu_valid_i;
    logic [4:0]  lsu_waddr_i;
    logic [63:0] lsu_wdata_i;
    logic        lsu_ready_o;
    logic [4:0]  dec_rs1_i, dec_rs2_i, dec_rd_i;
    logic        hazard_o;
    logic        reg_wen_o;
    logic [4:0]  reg_waddr_o;
    logic [63:0] reg_wdata_o;

    regs_wb_arbiter dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .alu_wen_i(alu_wen_i), .alu_waddr_i(alu_waddr_i), .alu_wdata_i(alu_wdata_i),
        .alu_hold_o(alu_hold_o),
        .lsu_valid_i(lsu_valid_i), .lsu_waddr_i(lsu_waddr_i), .lsu_wdata_i(lsu_wdata_i),
        .lsu_ready_o(lsu_ready_o),
        .dec_rs1_i(dec_rs1_i), .dec_rs2_i(dec_rs2_i), .dec_rd_i(dec_rd_i),
        .hazard_o(hazard_o),
        .reg_wen_o(reg_wen_o), .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        rst, aw, lv;
        logic [4:0]  aa, la, rs1, rs2, rd, ea;
        logic [63:0] ad, ld, ed;
        logic        ew, er, eh, eho;
    } vec_t;

    typedef struct {
        logic [4:0]  a;
        logic [63:0] d;
    } wr_t;

    vec_t tbl[$];
    wr_t  alu_q[$];
    wr_t  lsu_q[$];
    int   total  = 0;
    int   passed = 0;

    // ALU results carry an A1 top byte so the scoreboard can tell the sources apart
    function automatic logic [63:0] alu_d(input int a);
        return 64'hA100_0000_0000_0000 | 64'(a);
    endfunction

    function automatic logic [63:0] lsu_d(input int n);
        return 64'h0000_0000_B000_0000 | 64'(n);
    endfunction

    task automatic add(input int rst, input int aw, input int aa,
                       input int lv, input int la, input logic [63:0] ld,
                       input int rs1, input int rs2, input int rd,
                       input int ew, input int ea, input logic [63:0] ed,
                       input int er, input int eh, input int eho);
        vec_t v;
        v.rst = 1'(rst); v.aw = 1'(aw); v.aa = 5'(aa);
        v.ad  = (aw != 0) ? alu_d(aa) : 64'd0;
        v.lv  = 1'(lv); v.la = 5'(la); v.ld = ld;
        v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.rd = 5'(rd);
        v.ew  = 1'(ew); v.ea = 5'(ea); v.ed = ed;
        v.er  = 1'(er); v.eh = 1'(eh); v.eho = 1'(eho);
        tbl.push_back(v);
    endtask

    task automatic check(input string nm, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        wr_t  w;

        // rst aw aa | lv la ld | rs1 rs2 rd | ew ea ed | rdy haz hold
        add(1, 1, 7,  1, 7,  lsu_d(7),  7, 0, 0,  0, 0, '0,  0, 0, 0);
        for (int k = 0; k < 5; k++) add(0, 0, 0, 0, 0, '0, 0, 0, 0, 0, 0, '0, 1, 0, 0);
        add(0, 0, 0,  1, 5,  64'hAA,    5, 0, 0,  0, 0, '0,  1, 1, 0);
        add(0, 0, 0,  0, 0,  '0,        5, 0, 0,  1, 5, 64'hAA, 1, 1, 0);
        add(0, 1, 1,  1, 10, lsu_d(10), 0, 0, 0,  1, 1, alu_d(1), 1, 0, 0);
        add(0, 1, 2,  1, 11, lsu_d(11), 0, 0, 0,  1, 2, alu_d(2), 1, 0, 0);
        for (int k = 3; k <= 5; k++) add(0, 1, k, 0, 0, '0, 0, 0, 0, 1, k, alu_d(k), 0, 0, 0);
        add(0, 0, 0,  0, 0,  '0,        0, 0, 0,  1, 10, lsu_d(10), 0, 0, 1);
        for (int k = 6; k <= 9; k++) add(0, 1, k, 0, 0, '0, 0, 0, 0, 1, k, alu_d(k), 1, 0, 0);
        add(0, 0, 0,  0, 0,  '0,        0, 0, 0,  1, 11, lsu_d(11), 1, 0, 1);
        add(0, 0, 0,  0, 0,  '0,        0, 0, 0,  0, 0, '0,  1, 0, 0);
        add(0, 0, 0,  1, 20, lsu_d(20), 0, 0, 0,  0, 0, '0,  1, 0, 0);
        add(0, 0, 0,  1, 21, lsu_d(21), 0, 0, 0,  1, 20, lsu_d(20), 1, 0, 0);
        add(0, 0, 0,  1, 22, lsu_d(22), 0, 0, 21, 1, 21, lsu_d(21), 1, 1, 0);
        add(0, 0, 0,  1, 23, lsu_d(23), 0, 23, 0, 1, 22, lsu_d(22), 1, 1, 0);
        add(0, 0, 0,  1, 24, lsu_d(24), 30, 0, 0, 1, 23, lsu_d(23), 1, 0, 0);
        add(0, 0, 0,  1, 25, lsu_d(25), 0, 0, 0,  1, 24, lsu_d(24), 1, 0, 0);
        add(0, 0, 0,  0, 0,  '0,        0, 0, 0,  1, 25, lsu_d(25), 1, 0, 0);
        add(0, 0, 0,  1, 3,  lsu_d(3),  0, 0, 0,  0, 0, '0,  1, 0, 0);
        add(0, 1, 0,  0, 0,  '0,        0, 0, 0,  1, 3, lsu_d(3), 1, 0, 0);
        add(0, 0, 0,  1, 0,  lsu_d(0),  0, 0, 0,  0, 0, '0,  1, 0, 0);
        add(0, 1, 0,  0, 0,  '0,        0, 0, 0,  0, 0, '0,  1, 0, 0);
        add(0, 1, 1,  1, 12, lsu_d(12), 0, 0, 0,  1, 1, alu_d(1), 1, 0, 0);
        add(0, 1, 2,  1, 13, lsu_d(13), 0, 0, 0,  1, 2, alu_d(2), 1, 0, 0);
        for (int k = 3; k <= 5; k++) add(0, 1, k, 0, 0, '0, 0, 0, 0, 1, k, alu_d(k), 0, 0, 0);
        add(1, 0, 0,  1, 14, lsu_d(14), 12, 0, 0, 0, 0, '0,  0, 0, 1);
        add(0, 0, 0,  0, 0,  '0,        12, 0, 0, 0, 0, '0,  1, 0, 0);
        for (int k = 0; k < 3; k++) add(0, 0, 0, 0, 0, '0, 0, 0, 0, 0, 0, '0, 1, 0, 0);

        rst_i = 1'b1; alu_wen_i = 1'b0; alu_waddr_i = '0; alu_wdata_i = '0;
        lsu_valid_i = 1'b0; lsu_waddr_i = '0; lsu_wdata_i = '0;
        dec_rs1_i = '0; dec_rs2_i = '0; dec_rd_i = '0;
        repeat (2) @(posedge clk_i);

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            @(posedge clk_i);
            #1;
            rst_i = v.rst;
            alu_wen_i = v.aw; alu_waddr_i = v.aa; alu_wdata_i = v.ad;
            lsu_valid_i = v.lv; lsu_waddr_i = v.la; lsu_wdata_i = v.ld;
            dec_rs1_i = v.rs1; dec_rs2_i = v.rs2; dec_rd_i = v.rd;
            if (!v.rst && v.aw && (v.aa != 5'd0)) begin
                w.a = v.aa; w.d = v.ad;
                alu_q.push_back(w);
            end
            @(negedge clk_i);
            check($sformatf("row%0d {wen,waddr,wdata,ready,hazard,hold}", i),
                  {7'd0, reg_wen_o, reg_waddr_o, reg_wdata_o, lsu_ready_o, hazard_o, alu_hold_o},
                  {7'd0, v.ew, v.ea, v.ed, v.er, v.eh, v.eho});
            if (reg_wen_o) begin
                if (reg_wdata_o[63:56] == 8'hA1) begin
                    check($sformatf("row%0d alu_write_expected", i), 80'(alu_q.size() != 0), 80'd1);
                    if (alu_q.size() != 0) begin
                        w = alu_q.pop_front();
                        check($sformatf("row%0d alu_write_order", i),
                              {11'd0, reg_waddr_o, reg_wdata_o}, {11'd0, w.a, w.d});
                    end
                end else begin
                    check($sformatf("row%0d lsu_write_expected", i), 80'(lsu_q.size() != 0), 80'd1);
                    if (lsu_q.size() != 0) begin
                        w = lsu_q.pop_front();
                        check($sformatf("row%0d lsu_write_order", i),
                              {11'd0, reg_waddr_o, reg_wdata_o}, {11'd0, w.a, w.d});
                    end
                end
            end
            check($sformatf("row%0d alu_same_cycle pending", i), 80'(alu_q.size()), 80'd0);
            if (v.rst) lsu_q.delete();
            if (lsu_valid_i && lsu_ready_o && (lsu_waddr_i != 5'd0)) begin
                w.a = lsu_waddr_i; w.d = lsu_wdata_i;
                lsu_q.push_back(w);
            end
        end

        check("lsu_scoreboard_drained", 80'(lsu_q.size()), 80'd0);
        check("alu_scoreboard_drained", 80'(alu_q.size()), 80'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
